// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit-period helper.
// Kept free of transmitter specifics so a receiver can import it unchanged.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Truncate at both divisions so the period is a whole number of 16x ticks.
    function automatic int bit_cycles(input int clk_freq, input int baud);
        return 16 * (clk_freq / (baud * 16));
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses bit_end on the last cycle of every bit while run is high.
// restart reloads the count so a new frame always begins with a full bit period.
module uart_baud_gen #(
    parameter int BIT_CYC = 5200
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic bit_end
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BIT_CYC - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is written with <= only, so every always_ff reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= RELOAD;
        end else if (!run) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign bit_end = run && (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a shift FSM, 8 data bits LSB first,
// optional parity and one or two stop bits; back-to-back frames leave no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 19200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       sout,
    output logic       busy
);

    localparam int   BIT_CYC   = bit_cycles(CLK_FREQ, BAUD);
    localparam logic ODD       = (PARITY == PAR_ODD);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    uart_state_t state;
    logic [7:0]  hold;
    logic        hold_full;
    logic [7:0]  shifter;
    logic        par_bit;
    logic [2:0]  bit_idx;
    logic        stop_idx;

    logic bit_end;
    logic take;
    logic last_stop;
    logic xfer;
    logic hold_full_next;

    // NOTE: every always_comb output gets a value first, so no path can infer a latch.
    always_comb begin
        take           = tx_valid && tx_ready;
        last_stop      = (state == ST_STOP) && bit_end && (stop_idx == LAST_STOP);
        xfer           = hold_full && ((state == ST_IDLE) || last_stop);
        hold_full_next = hold_full;
        if (xfer) begin
            hold_full_next = 1'b0;
        end else if (take) begin
            hold_full_next = 1'b1;
        end
    end

    uart_baud_gen #(
        .BIT_CYC (BIT_CYC)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (xfer),
        .run     (state != ST_IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sout      <= 1'b1;
            tx_ready  <= 1'b1;
            hold      <= '0;
            hold_full <= 1'b0;
            shifter   <= '0;
            par_bit   <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
        end else begin
            hold_full <= hold_full_next;
            tx_ready  <= !hold_full_next;
            if (take) begin
                hold <= tx_data;
            end

            // sout is driven from the current state, so the line trails the FSM by one cycle.
            unique case (state)
                ST_IDLE: begin
                    sout <= 1'b1;
                end
                ST_START: begin
                    sout <= 1'b0;
                    if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    sout <= shifter[0];
                    if (bit_end) begin
                        shifter <= {1'b0, shifter[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    sout <= par_bit;
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    sout <= 1'b1;
                    if (bit_end) begin
                        if (last_stop) begin
                            stop_idx <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    sout  <= 1'b1;
                end
            endcase

            // Placed after the case so a transfer out of the final stop bit overrides ST_IDLE.
            if (xfer) begin
                state   <= ST_START;
                shifter <= hold;
                par_bit <= (^hold) ^ ODD;
            end
        end
    end

    assign busy = (state != ST_IDLE) || hold_full;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: one default-rate instance plus three fast instances
// covering parity modes, two stop bits, back-to-back frames, mid-frame reset and random traffic.
module tb_uart_tx;

    localparam int FAST_FREQ = 100000000;
    localparam int FAST_BAUD = 5000000;
    localparam int FAST_BC   = 16;
    localparam int DEF_BC    = 5200;

    logic       clk = 1'b0;
    logic [3:0] rst;
    logic [3:0] tx_valid;
    logic [3:0] tx_ready;
    logic [3:0] sout;
    logic [3:0] busy;
    logic [7:0] tx_data [4];

    int         total = 0;
    int         bad = 0;
    int         coincide = 0;
    logic [7:0] sb [$];
    string      mon;
    logic       par_seen [2];

    always #5 clk = ~clk;

    uart_tx u0 (
        .clk(clk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .sout(sout[0]), .busy(busy[0])
    );
    uart_tx #(.CLK_FREQ(FAST_FREQ), .BAUD(FAST_BAUD), .PARITY(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .sout(sout[1]), .busy(busy[1])
    );
    uart_tx #(.CLK_FREQ(FAST_FREQ), .BAUD(FAST_BAUD), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .sout(sout[2]), .busy(busy[2])
    );
    uart_tx #(.CLK_FREQ(FAST_FREQ), .BAUD(FAST_BAUD), .PARITY(2), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst[3]), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .sout(sout[3]), .busy(busy[3])
    );

    // A handshake landing on a hold->shifter transfer cycle must never happen.
    always @(posedge clk) begin
        if ((u0.xfer && tx_valid[0] && tx_ready[0]) || (u1.xfer && tx_valid[1] && tx_ready[1]) ||
            (u2.xfer && tx_valid[2] && tx_ready[2]) || (u3.xfer && tx_valid[3] && tx_ready[3]))
            coincide++;
    end

    task automatic wait_start(input int g, input int limit, input string name, output bit ok);
        int n = 0;
        while (sout[g] !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (sout[g] === 1'b0);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s start: sout=%b after %0d cycles, wanted 0", name, sout[g], limit);
        end
    endtask

    // Called on the first low cycle of a start bit; checks every cycle of the frame.
    task automatic check_frame(input int g, input int bc, input int par, input int stops,
                               input string name, output logic pbit);
        logic [7:0] exp_b;
        logic [7:0] got;
        logic       exp_bits [12];
        int         nb;
        int         miss;
        logic       v;
        pbit = 1'bx;
        got  = '0;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard: frame seen, expected queue empty", name);
            return;
        end
        exp_b = sb.pop_front();
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1+i] = exp_b[i];
        nb = 9;
        if (par != 0) begin
            exp_bits[9] = (^exp_b) ^ (par == 2);
            nb = 10;
        end
        for (int s = 0; s < stops; s++) begin
            exp_bits[nb] = 1'b1;
            nb++;
        end
        for (int k = 0; k < nb; k++) begin
            miss = 0;
            for (int c = 0; c < bc; c++) begin
                v = sout[g];
                if (v !== exp_bits[k]) miss++;
                if (c == bc / 2) begin
                    if (k >= 1 && k <= 8) got[k-1] = v;
                    if (par != 0 && k == 9) pbit = v;
                end
                @(negedge clk);
            end
            total++;
            if (miss != 0) begin
                bad++;
                $display("FAIL %s bit %0d: sout wrong on %0d of %0d cycles, wanted %b",
                         name, k, miss, bc, exp_bits[k]);
            end
        end
        total++;
        if (got !== exp_b) begin
            bad++;
            $display("FAIL %s byte: got %h, wanted %h", name, got, exp_b);
        end
        mon = {mon, $sformatf("%c", got)};
    endtask

    task automatic drive_pair(input int g, input logic [7:0] b0, input logic [7:0] b1,
                              input string name);
        logic [7:0] bs [2];
        int i = 0;
        int cyc = 0;
        bs[0] = b0;
        bs[1] = b1;
        while (i < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            tx_valid[g] = 1'b1;
            tx_data[g]  = bs[i];
            if (tx_ready[g]) begin
                sb.push_back(bs[i]);
                i++;
            end
        end
        @(negedge clk);
        tx_valid[g] = 1'b0;
        total++;
        if (i != 2) begin
            bad++;
            $display("FAIL %s handshakes: got %0d, wanted 2", name, i);
        end
    endtask

    task automatic run_pair(input int g, input int bc, input int par, input int stops,
                            input logic [7:0] b0, input logic [7:0] b1, input string name);
        int   rises = 0;
        bit   done = 0;
        bit   ok;
        logic prev;
        logic p0;
        logic p1;
        sb.delete();
        mon  = "";
        prev = tx_ready[g];
        fork
            drive_pair(g, b0, b1, name);
            begin
                wait_start(g, 4 * bc, name, ok);
                if (ok) begin
                    check_frame(g, bc, par, stops, name, p0);
                    total++;
                    if (sout[g] !== 1'b0) begin
                        bad++;
                        $display("FAIL %s gap: sout=%b after last stop, wanted 0", name, sout[g]);
                    end
                    check_frame(g, bc, par, stops, name, p1);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (tx_ready[g] && !prev) rises++;
                    prev = tx_ready[g];
                end
            end
        join
        par_seen[0] = p0;
        par_seen[1] = p1;
        $display("monitor %s: \"%s\"", name, mon);
        total++;
        if (rises != 2) begin
            bad++;
            $display("FAIL %s ready_rises: got %0d, wanted 2", name, rises);
        end
        total++;
        if (sout[g] !== 1'b1 || busy[g] !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after: sout=%b busy=%b, wanted 1 0", name, sout[g], busy[g]);
        end
    endtask

    task automatic test_reset();
        rst      = '1;
        tx_valid = '0;
        for (int g = 0; g < 4; g++) tx_data[g] = '0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            total += 3;
            if (sout[g] !== 1'b1) begin
                bad++;
                $display("FAIL reset sout[%0d]: got %b, wanted 1", g, sout[g]);
            end
            if (tx_ready[g] !== 1'b1) begin
                bad++;
                $display("FAIL reset tx_ready[%0d]: got %b, wanted 1", g, tx_ready[g]);
            end
            if (busy[g] !== 1'b0) begin
                bad++;
                $display("FAIL reset busy[%0d]: got %b, wanted 0", g, busy[g]);
            end
        end
        rst = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_default_a();
        logic p;
        sb.delete();
        mon = "";
        @(negedge clk);
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h41;
        sb.push_back(8'h41);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        tx_data[0]  = 8'hFF;
        total += 3;
        if (tx_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL A ready_after_accept: got %b, wanted 0", tx_ready[0]);
        end
        if (busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL A busy_after_accept: got %b, wanted 1", busy[0]);
        end
        if (sout[0] !== 1'b1) begin
            bad++;
            $display("FAIL A sout_edge_n: got %b, wanted 1", sout[0]);
        end
        @(negedge clk);
        total++;
        if (sout[0] !== 1'b1) begin
            bad++;
            $display("FAIL A early_start_n1: got %b, wanted 1", sout[0]);
        end
        @(negedge clk);
        total++;
        if (sout[0] !== 1'b0) begin
            bad++;
            $display("FAIL A start_n2: got %b, wanted 0", sout[0]);
        end
        check_frame(0, DEF_BC, 0, 1, "A", p);
        $display("monitor A: \"%s\"", mon);
        total += 2;
        if (mon != "A") begin
            bad++;
            $display("FAIL A monitor: got \"%s\", wanted \"A\"", mon);
        end
        if (sout[0] !== 1'b1 || busy[0] !== 1'b0 || tx_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL A idle_after: sout=%b busy=%b ready=%b, wanted 1 0 1",
                     sout[0], busy[0], tx_ready[0]);
        end
    endtask

    task automatic test_parity();
        run_pair(2, FAST_BC, 1, 1, 8'h07, 8'h07, "even");
        total++;
        if (par_seen[0] !== 1'b1) begin
            bad++;
            $display("FAIL even parity_bit: got %b, wanted 1", par_seen[0]);
        end
        run_pair(3, FAST_BC, 2, 2, 8'h07, 8'h55, "odd_2stop");
        total += 2;
        if (par_seen[0] !== 1'b0) begin
            bad++;
            $display("FAIL odd parity_bit_07: got %b, wanted 0", par_seen[0]);
        end
        if (par_seen[1] !== 1'b1) begin
            bad++;
            $display("FAIL odd parity_bit_55: got %b, wanted 1", par_seen[1]);
        end
    endtask

    task automatic test_back_to_back();
        run_pair(1, FAST_BC, 0, 1, 8'h48, 8'h69, "hi");
        total++;
        if (mon != "Hi") begin
            bad++;
            $display("FAIL hi monitor: got \"%s\", wanted \"Hi\"", mon);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int lows = 0;
        sb.delete();
        drive_pair(1, 8'h3C, 8'h5A, "rst_load");
        wait_start(1, 4 * FAST_BC, "rst_load", ok);
        repeat (4 * FAST_BC + FAST_BC / 2) @(negedge clk);
        total++;
        if (tx_ready[1] !== 1'b0 || busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL rst held_before: ready=%b busy=%b, wanted 0 1", tx_ready[1], busy[1]);
        end
        rst[1]      = 1'b1;
        tx_valid[1] = 1'b1;
        tx_data[1]  = 8'hC3;
        @(negedge clk);
        rst[1]      = 1'b0;
        tx_valid[1] = 1'b0;
        total++;
        if (sout[1] !== 1'b1 || tx_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL rst mid_frame: sout=%b ready=%b busy=%b, wanted 1 1 0",
                     sout[1], tx_ready[1], busy[1]);
        end
        @(negedge clk);
        rst[1]      = 1'b1;
        tx_valid[1] = 1'b1;
        tx_data[1]  = 8'h0F;
        @(negedge clk);
        rst[1]      = 1'b0;
        tx_valid[1] = 1'b0;
        total++;
        if (tx_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL rst over_handshake: ready=%b busy=%b, wanted 1 0", tx_ready[1], busy[1]);
        end
        repeat (20 * FAST_BC) begin
            @(negedge clk);
            if (sout[1] !== 1'b1 || busy[1] !== 1'b0) lows++;
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("FAIL rst no_frame: %0d active cycles after reset, wanted 0", lows);
        end
        sb.delete();
    endtask

    task automatic test_random();
        int   i = 0;
        int   cyc = 0;
        bit   ok;
        logic p;
        sb.delete();
        mon = "";
        fork
            begin
                while (i < 6 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    tx_valid[1] = ($urandom_range(0, 3) == 0);
                    tx_data[1]  = 8'($urandom);
                    if (tx_valid[1] && tx_ready[1]) begin
                        sb.push_back(tx_data[1]);
                        i++;
                    end
                end
                @(negedge clk);
                tx_valid[1] = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    wait_start(1, 1000, "random", ok);
                    if (!ok) break;
                    check_frame(1, FAST_BC, 0, 1, "random", p);
                end
            end
        join
        repeat (4) @(negedge clk);
        total += 2;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL random leftover: %0d bytes never sent, wanted 0", sb.size());
        end
        if (coincide != 0) begin
            bad++;
            $display("FAIL handshake_on_transfer: got %0d cycles, wanted 0", coincide);
        end
    endtask

    initial begin
        test_reset();
        test_default_a();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, is the clk frequency in Hz (10 ns period).
REQ-002 Parameter BAUD, default 19200, is the line rate in bit/s.
REQ-003 Parameter PARITY, default 0, selects the parity bit: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1, is the stop bit count; legal values are 1 and 2.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 tx_data  input  8  byte to send; sampled on handshake.
REQ-009 tx_valid  input  1  tx_data is valid.
REQ-010 tx_ready  output  1  holding register is empty; the byte is accepted when tx_valid && tx_ready.
REQ-011 sout  output  1  serial line; idle high; registered output.
REQ-012 busy  output  1  high while a frame is on the line or the holding register is full.

Function
REQ-013 Bit period BIT_CYC SHALL be 16*(CLK_FREQ/(BAUD*16)) clk cycles, integer-truncated at each division (5200 at defaults), to match the team's 16x-oversampling receive monitor.
REQ-014 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
REQ-015 The block SHALL have a one-entry holding register; tx_ready SHALL equal !hold_full, driven from a register with no combinational path from tx_valid.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE with hold_full, the FSM SHALL move the held byte to the shifter, clear hold_full, enter START and drive sout=0 on the next edge.
REQ-018 Latency: a byte accepted in IDLE at edge N SHALL drive sout low from edge N+2; the start bit is not asserted before N+1.
REQ-019 Each state SHALL last exactly BIT_CYC cycles, timed by a down-counter reloaded at every bit boundary.
REQ-020 DATA SHALL use a 3-bit bit index that wraps 7->0 on exit.
REQ-021 DATA SHALL exit to PARITY when PARITY!=0, otherwise to STOP.
REQ-022 Parity bit value SHALL be XOR of the data bits for even parity and its inverse for odd parity.
REQ-023 On the last cycle of the final stop bit with hold_full, the FSM SHALL go directly to START, so there is zero idle gap between frames.
REQ-024 On the last cycle of the final stop bit without hold_full, the FSM SHALL go to IDLE and sout SHALL stay high.
REQ-025 A handshake while a frame is in flight SHALL load the holding register only; the shifter is unaffected.
REQ-026 A handshake in the same cycle as a hold->shifter transfer cannot occur, because tx_ready is 0 that cycle; this SHALL be asserted in verification.
REQ-027 tx_data changing while tx_ready=0 SHALL have no effect.
REQ-028 busy SHALL be (state!=IDLE) || hold_full.

Reset
REQ-029 On rst at a clk edge: state=IDLE, sout=1, tx_ready=1, busy=0, hold_full=0, counters=0, shifter=0.
REQ-030 Reset mid-frame SHALL abort the frame, with sout high from the next edge; any held byte is discarded.
REQ-031 rst SHALL take priority over any concurrent handshake.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, the PARITY encodings (PAR_NONE, PAR_EVEN, PAR_ODD) and a constant function computing BIT_CYC from CLK_FREQ and BAUD.
REQ-033 One sub-module, uart_baud_gen, SHALL produce a one-cycle bit_end pulse every BIT_CYC cycles; it is restarted by a frame-start strobe, not free-running.
REQ-034 The FSM, holding register and shifter SHALL reside in uart_tx.
REQ-035 uart_pkg SHALL be reused by any future synthesizable receiver.

Verification
REQ-036 Send 0x41 after reset (defaults): sout low for 5200 cycles, then 1,0,0,0,0,0,1,0 at 5200 cycles each, then high; the monitor prints "A".
REQ-037 Back-to-back 0x48, 0x69 with tx_valid held high: second start bit begins immediately after the first stop bit (gap 0); tx_ready rises once per transfer; the monitor prints "Hi".
REQ-038 PARITY=1, byte 0x07: parity bit =1 after bit 7; PARITY=2, same byte: parity bit =0.
REQ-039 STOP_BITS=2, byte 0x55: high stop period lasts 10400 cycles before the next start bit.
REQ-040 rst pulse during data bit 3 with a held byte present: sout=1, tx_ready=1, busy=0 next cycle; no further frame is emitted.
REQ-041 Random tx_valid with tx_data changing while tx_ready=0: only handshaked bytes appear, in order, and no handshake coincides with a transfer cycle.
